// File: rtl/btn_event_queue.sv
// Button event queue: turns settled edges of the debounced input vector into
// {[ts,] level, idx} words in a FWFT FIFO. Optional macro: BTNEVT_TIMESTAMP_EN.
module btn_event_queue #(
    parameter int NIN    = 21,
    parameter int LGFIFO = 4,
    parameter int TSBITS = 16,
    localparam int IW    = $clog2(NIN),
`ifdef BTNEVT_TIMESTAMP_EN
    localparam int EW    = TSBITS + 1 + IW
`else
    localparam int EW    = 1 + IW
`endif
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [NIN-1:0]    i_debounced,
    input  logic              i_rd,
    output logic [EW-1:0]     o_event,
    output logic              o_empty,
    output logic [LGFIFO:0]   o_count,
    output logic              o_overflow,
    output logic              o_int
);

    localparam logic [LGFIFO:0] DEPTH = (LGFIFO+1)'(1) << LGFIFO;

    logic [NIN-1:0]  r_prev;
    logic [NIN-1:0]  pending;
    logic [NIN-1:0]  diff;
    logic [NIN-1:0]  clr;
    logic [IW-1:0]   svc_idx;
    logic            svc_vld;
    logic            full;
    logic            rd_ok;
    logic            wr_ok;
    logic            drop;
    logic [EW-1:0]   wr_data;
    logic [LGFIFO:0] wr_ptr;
    logic [LGFIFO:0] rd_ptr;
    logic [EW-1:0]   mem [2**LGFIFO];

    assign diff = i_debounced ^ r_prev;

    // Downward scan so the last hit is the lowest set bit.
    always_comb begin
        svc_idx = '0;
        svc_vld = 1'b0;
        for (int i = NIN - 1; i >= 0; i--) begin
            if (pending[i]) begin
                svc_idx = IW'(i);
                svc_vld = 1'b1;
            end
        end
    end

    assign clr     = svc_vld ? (NIN'(1) << svc_idx) : '0;
    assign o_empty = (o_count == '0);
    assign full    = (o_count == DEPTH);
    assign rd_ok   = i_rd & ~o_empty;
    assign wr_ok   = svc_vld & (~full | rd_ok);
    assign drop    = svc_vld & ~wr_ok;

`ifdef BTNEVT_TIMESTAMP_EN
    logic [TSBITS-1:0] ts;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) ts <= '0;
        else         ts <= ts + 1'b1;
    end

    assign wr_data = {ts, r_prev[svc_idx], svc_idx};
`else
    assign wr_data = {r_prev[svc_idx], svc_idx};
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_prev  <= '0;
            pending <= '0;
        end else begin
            r_prev  <= i_debounced;
            // Double toggles cancel; a fresh edge on the serviced bit re-arms it.
            pending <= (pending & ~clr) ^ diff;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_ok) mem[wr_ptr[LGFIFO-1:0]] <= wr_data;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_count    <= '0;
            o_overflow <= 1'b0;
            o_int      <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   o_count <= o_count + 1'b1;
                2'b01:   o_count <= o_count - 1'b1;
                default: o_count <= o_count;
            endcase
            if (drop)       o_overflow <= 1'b1;
            else if (rd_ok) o_overflow <= 1'b0;
            o_int <= ~o_empty | o_overflow;
        end
    end

    assign o_event = mem[rd_ptr[LGFIFO-1:0]];

endmodule

// File: tb/tb_btn_event_queue.sv
// Directed bench for btn_event_queue: latency, ordering, cancellation,
// overflow, full-with-read and mid-burst reset.
module tb_btn_event_queue;

    localparam int NIN    = 21;
    localparam int LGFIFO = 4;
    localparam int IW     = 5;
`ifdef BTNEVT_TIMESTAMP_EN
    localparam int EW     = 16 + 1 + IW;
`else
    localparam int EW     = 1 + IW;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rd  = 1'b0;
    logic [NIN-1:0]  deb = '0;
    logic [EW-1:0]   ev;
    logic            empty;
    logic [LGFIFO:0] cnt;
    logic            ovf;
    logic            intr;

    int total = 0;
    int bad   = 0;
    int q[$];

    btn_event_queue #(.NIN(NIN), .LGFIFO(LGFIFO), .TSBITS(16)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_debounced (deb),
        .i_rd        (rd),
        .o_event     (ev),
        .o_empty     (empty),
        .o_count     (cnt),
        .o_overflow  (ovf),
        .o_int       (intr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] head();
        return 32'(ev[IW:0]);
    endfunction

    task automatic pop();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

`ifdef BTNEVT_TIMESTAMP_EN
    logic [15:0] ts1;
`endif

    initial begin
        // reset state
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        tick();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_int",   32'(intr),  32'd0);
        chk("rst_count", 32'(cnt),   32'd0);
        chk("rst_ovf",   32'(ovf),   32'd0);

        // 1: single press on bit 3, two-clock latency, int one clock later
        deb[3] = 1'b1;
        tick();
        chk("t1_empty_n", 32'(empty), 32'd1);
        tick();
        chk("t1_count",  32'(cnt),  32'd1);
        chk("t1_event",  head(),    32'h23);
        chk("t1_int_lag", 32'(intr), 32'd0);
        tick();
        chk("t1_int",    32'(intr), 32'd1);
        pop();
        chk("t1_drain",  32'(cnt),  32'd0);

        // 2: bits 0,7,20 together, written on consecutive clocks
        deb[0] = 1'b1; deb[7] = 1'b1; deb[20] = 1'b1;
        tick();
        chk("t2_c0", 32'(cnt), 32'd0);
        tick();
        chk("t2_c1", 32'(cnt), 32'd1);
        tick();
        chk("t2_c2", 32'(cnt), 32'd2);
        tick();
        chk("t2_c3", 32'(cnt), 32'd3);
        chk("t2_h0", head(), 32'h20);
        pop();
        chk("t2_h1", head(), 32'h27);
        pop();
        chk("t2_h2", head(), 32'h34);
        pop();
        chk("t2_empty", 32'(empty), 32'd1);

        // 3: bit 5 toggles twice while queued behind 0/7/20 releases
        deb[0] = 1'b0; deb[7] = 1'b0; deb[20] = 1'b0; deb[5] = 1'b1;
        tick();
        deb[5] = 1'b0;
        repeat (4) tick();
        chk("t3_count", 32'(cnt), 32'd3);
        chk("t3_h0", head(), 32'h00);
        pop();
        chk("t3_h1", head(), 32'h07);
        pop();
        chk("t3_h2", head(), 32'h14);
        pop();
        chk("t3_empty", 32'(cnt), 32'd0);

        // 4: 17 rising edges (bits 0..17 except 3, already high), no reads
        deb = 21'h3FFFF;
        repeat (18) tick();
        chk("t4_count", 32'(cnt), 32'd16);
        chk("t4_ovf",   32'(ovf), 32'd1);
        tick();
        chk("t4_int",   32'(intr), 32'd1);
        chk("t4_head",  head(), 32'h20);
        pop();
        chk("t4_ovf_clr", 32'(ovf), 32'd0);
        chk("t4_count15", 32'(cnt), 32'd15);
        chk("t4_head2",   head(), 32'h21);

        // 5: refill to full, then a read coinciding with a new event
        deb[18] = 1'b1;
        tick();
        tick();
        chk("t5_full", 32'(cnt), 32'd16);
        deb[19] = 1'b1;
        tick();
        pop();
        chk("t5_count", 32'(cnt), 32'd16);
        chk("t5_ovf",   32'(ovf), 32'd0);
        q.push_back(2);
        for (int i = 4; i <= 16; i++) q.push_back(i);
        q.push_back(18);
        q.push_back(19);
        foreach (q[k]) begin
            chk($sformatf("t5_drain%0d", k), head(), 32'h20 | 32'(q[k]));
            pop();
        end
        chk("t5_empty", 32'(empty), 32'd1);
        chk("t5_ovf2",  32'(ovf),   32'd0);

        // 6: reset with bits 0..2 release events in flight
        deb = 21'h0FFFF8;
        tick();
        tick();
        chk("t6_pre", 32'(cnt), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_count", 32'(cnt),   32'd0);
        chk("t6_rst_empty", 32'(empty), 32'd1);
        chk("t6_rst_ovf",   32'(ovf),   32'd0);
        chk("t6_rst_int",   32'(intr),  32'd0);
        deb = 21'h000210;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("t6_count", 32'(cnt), 32'd2);
        chk("t6_h0", head(), 32'h24);
`ifdef BTNEVT_TIMESTAMP_EN
        ts1 = ev[EW-1 -: 16];
`endif
        pop();
        chk("t6_h1", head(), 32'h29);
`ifdef BTNEVT_TIMESTAMP_EN
        chk("t6_ts_gap", 32'(16'(ev[EW-1 -: 16] - ts1)), 32'd1);
`endif
        pop();
        chk("t6_empty", 32'(empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
